capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Capture/readout controller for the analyzer's 128 x 8 distributed sample RAM.
- Writes an 8-bit probe stream into the RAM as a circular buffer and holds a programmable pre-trigger window.
- Stops capture after a masked-pattern trigger plus the post-trigger fill.
- Then streams all 128 samples out, oldest first, over a valid/ready port to the host/UART side.

Parameters:
- DW, 8: sample width.
- AW, 7: RAM address width.
- DEPTH, 128: RAM entries; must equal 2**AW.

Ports:
- CLK  in  1  system clock; everything registered on posedge.
- RST  in  1  synchronous, active-high reset.
- ARM  in  1  start capture; sampled in IDLE or DONE only.
- ABORT  in  1  return to IDLE from any state.
- SAMPLE_EN  in  1  sample strobe; SAMPLE_IN is valid this cycle.
- SAMPLE_IN  in  DW  probe data.
- TRIG_MASK  in  DW  trigger bit-enable mask; latched on ARM.
- TRIG_VALUE  in  DW  trigger pattern; latched on ARM.
- PRE_COUNT  in  AW  pre-trigger sample count; latched on ARM.
- RD_START  in  1  begin readout; accepted in DONE only.
- RD_READY  in  1  consumer accepts RD_DATA.
- RD_DATA  out  DW  readout sample.
- RD_VALID  out  1  RD_DATA is valid.
- RD_LAST  out  1  qualifies the 128th readout beat.
- BUSY  out  1  high in PRETRIG, WAIT_TRIG, POSTTRIG and READOUT.
- DONE  out  1  capture complete, buffer ready for readout.
- TRIG_ADDR  out  AW  RAM address that holds the trigger sample.

Behaviour:
- Reset: state IDLE. Pointers, counters and latched config are 0. All outputs are 0, including TRIG_ADDR and RD_DATA.
- RAM port usage: one port. WE = (capture state && SAMPLE_EN). DIN = SAMPLE_IN.
  - Read timing: with WE=0, RAM DOUT = RAM[ADDR of previous cycle] (1-cycle latency).
  - With WE=1, DOUT holds its previous value.
- Trigger match: ((SAMPLE_IN ^ trig_value) & trig_mask) == 0, evaluated only on SAMPLE_EN cycles. Mask 0 matches the first eligible sample.
- IDLE:
  - ARM: latch config, wr_ptr=0, cnt=0.
  - If PRE_COUNT=0 go to WAIT_TRIG, else go to PRETRIG.
- PRETRIG:
  - Each SAMPLE_EN: write RAM[wr_ptr], wr_ptr++ (127 wraps to 0), cnt++.
  - Triggers are ignored.
  - When cnt reaches pre_count (on the write that makes it equal), go to WAIT_TRIG.
- WAIT_TRIG:
  - Each SAMPLE_EN: write RAM[wr_ptr], wr_ptr++ with wrap. The buffer keeps overwriting.
  - On a match: the matching sample is written, TRIG_ADDR <= wr_ptr (its address), and cnt <= DEPTH-1-pre_count.
  - If that cnt is 0 go to DONE, else go to POSTTRIG.
- POSTTRIG:
  - Each SAMPLE_EN: write, wr_ptr++, cnt--.
  - The write that makes cnt 0 goes to DONE.
  - Oldest sample is then at wr_ptr (= TRIG_ADDR - pre_count mod 128).
- DONE:
  - DONE=1, BUSY=0.
  - RD_START: rd_ptr <= wr_ptr, beat count <= 0, go to READOUT.
  - ARM: re-arm as from IDLE. ARM and RD_START together: ARM wins.
- READOUT:
  - ADDR = rd_ptr.
  - The first RD_VALID rises 2 cycles after RD_START is accepted: address issue, then RAM latency.
  - A beat transfers when RD_VALID && RD_READY. rd_ptr advances (with wrap) only when the output register is empty or transferring. ADDR is held while stalled, so RD_DATA stays stable; no beat is dropped or duplicated.
  - RD_LAST on beat 128. After its transfer: RD_VALID=0, DONE=0, go to IDLE.
- ABORT: highest priority in every state. Next cycle is IDLE; DONE, BUSY and RD_VALID are 0; no write occurs that cycle. ABORT+ARM together: stays IDLE.
- RST mid-capture or mid-readout: identical to reset. RAM contents are undefined and not cleared.
- SAMPLE_EN gaps: the FSM holds state; counters advance only on strobes.

Decomposition:
- Shared package/include `dla_defs`: DW, AW, DEPTH, and the state encodings S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ as 3-bit localparams.
- One sub-module is natural: `capture_ram_128x8`, the team's single-port distributed RAM (DIN/DOUT/ADDR/WE/CLK) described above.
- The controller owns the FSM, pointers, trigger compare and readout skid logic.

Test Plan:
- PRE_COUNT=16, MASK=0xFF, VALUE=0xA5. Stream 0x00,0x01,…; inject 0xA5 after 40 samples.
  -> TRIG_ADDR=40. Readout yields 128 beats: first = sample 24, beat 17 = 0xA5, RD_LAST on beat 128.
- MASK=0x00, PRE_COUNT=0: first SAMPLE_EN after ARM triggers.
  -> TRIG_ADDR=0; DONE after exactly 128 strobes; readout starts at addr 0.
- PRE_COUNT=127: trigger on sample 200.
  -> DONE in the same cycle as the trigger write (no POSTTRIG). TRIG_ADDR=200 mod 128=72. First readout beat = sample 73.
- Readout with RD_READY toggled 1,0,0,1 repeating.
  -> exactly 128 beats, ascending order, RD_DATA stable across stalls, no duplicates.
- ABORT asserted in WAIT_TRIG together with a matching sample.
  -> no RAM write; next cycle IDLE, BUSY=0, DONE=0. A subsequent ARM captures normally.
- RST pulse mid-READOUT (beat 50).
  -> all outputs 0 the next cycle, state IDLE, no further RD_VALID.

Source files
------------

// File: rtl/dla_defs.sv
// ----------------------------------------------------------------------------
// dla_defs
//   Shared definitions for the analyzer capture path: sample/RAM geometry,
//   the capture_sequencer state encoding and the masked trigger compare.
// ----------------------------------------------------------------------------
package dla_defs;

    localparam int DW    = 8;    // sample width
    localparam int AW    = 7;    // RAM address width
    localparam int DEPTH = 128;  // RAM entries, equals 2**AW

    // Controller states. The 3-bit encodings are fixed so debug tooling can
    // decode a raw state value.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_READ = 3'd5
    } state_t;

    // A sample matches when every bit enabled in the mask equals the pattern.
    // An all-zero mask matches any sample.
    function automatic logic trig_hit(input logic [DW-1:0] sample,
                                      input logic [DW-1:0] value,
                                      input logic [DW-1:0] mask);
        return ((sample ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/capture_ram_128x8.sv
// ----------------------------------------------------------------------------
// capture_ram_128x8
//   Single-port 128 x 8 distributed sample RAM.
//   Ports:
//     CLK   clock
//     WE    write enable: RAM[ADDR] <= DIN
//     ADDR  address
//     DIN   write data
//     DOUT  registered read data; RAM[ADDR] of the previous cycle when WE=0,
//           holds its value on write cycles
//   Contents are not reset.
// ----------------------------------------------------------------------------
module capture_ram_128x8
    import dla_defs::*;
(
    input  logic          CLK,
    input  logic          WE,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[ADDR] <= DIN;
        end else begin
            DOUT <= mem[ADDR];
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// ----------------------------------------------------------------------------
// capture_sequencer
//   Capture/readout controller for the analyzer's 128 x 8 sample RAM. Writes
//   the probe stream into the RAM as a circular buffer, keeps a programmable
//   pre-trigger window, stops after a masked-pattern trigger plus the
//   post-trigger fill, then streams all 128 samples out oldest first.
//
//   Ports:
//     CLK, RST            clock, synchronous active-high reset
//     ARM                 start capture (IDLE or DONE only); latches
//                         TRIG_MASK, TRIG_VALUE, PRE_COUNT
//     ABORT               back to IDLE from any state, highest priority
//     SAMPLE_EN/SAMPLE_IN probe strobe and data
//     RD_START            begin readout (DONE only)
//     RD_READY/RD_VALID   readout handshake, RD_DATA, RD_LAST on beat 128
//     BUSY                capturing or reading out
//     DONE                capture complete (held through readout)
//     TRIG_ADDR           RAM address of the trigger sample
//
//   Readout handshake: a beat transfers on a cycle where RD_VALID and
//   RD_READY are both high. Once RD_VALID is raised, RD_DATA and RD_LAST stay
//   stable until that beat transfers; RD_VALID does not depend on RD_READY.
//
//   The RAM output register serves as the readout output register: RD_DATA is
//   the RAM DOUT itself. While a beat is stalled the same address is re-read
//   so DOUT stays put; on a transfer the next address is issued in the same
//   cycle, giving one beat per cycle under continuous RD_READY.
// ----------------------------------------------------------------------------
module capture_sequencer
    import dla_defs::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          ARM,
    input  logic          ABORT,
    input  logic          SAMPLE_EN,
    input  logic [DW-1:0] SAMPLE_IN,
    input  logic [DW-1:0] TRIG_MASK,
    input  logic [DW-1:0] TRIG_VALUE,
    input  logic [AW-1:0] PRE_COUNT,
    input  logic          RD_START,
    input  logic          RD_READY,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_VALID,
    output logic          RD_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] TRIG_ADDR
);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] beat_cnt;
    logic [AW-1:0] pre_count;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic [AW-1:0] trig_addr;
    logic          rd_valid;

    logic          capturing;
    logic          xfer;
    logic          hit;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] cnt_inc;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] rd_ptr_inc;

    assign capturing  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign xfer       = (state == S_READ) && rd_valid && RD_READY;
    assign hit        = trig_hit(SAMPLE_IN, trig_value, trig_mask);
    assign post_cnt   = AW'(DEPTH - 1) - pre_count;
    assign cnt_inc    = cnt + 1'b1;
    assign wr_ptr_inc = wr_ptr + 1'b1;  // natural wrap 127 -> 0
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // An aborted or reset cycle must not disturb the buffer.
    assign ram_we = capturing && SAMPLE_EN && !ABORT && !RST;

    // Capture writes at wr_ptr. Readout re-reads rd_ptr while stalled and
    // issues the following address on the cycle the current beat transfers.
    always_comb begin
        ram_addr = rd_ptr;
        if (capturing) begin
            ram_addr = wr_ptr;
        end else if (xfer) begin
            ram_addr = rd_ptr_inc;
        end
    end

    capture_ram_128x8 u_ram (
        .CLK  (CLK),
        .WE   (ram_we),
        .ADDR (ram_addr),
        .DIN  (SAMPLE_IN),
        .DOUT (ram_dout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            beat_cnt   <= '0;
            pre_count  <= '0;
            trig_mask  <= '0;
            trig_value <= '0;
            trig_addr  <= '0;
            rd_valid   <= 1'b0;
        end else if (ABORT) begin
            state    <= S_IDLE;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (ARM) begin
                        trig_mask  <= TRIG_MASK;
                        trig_value <= TRIG_VALUE;
                        pre_count  <= PRE_COUNT;
                        wr_ptr     <= '0;
                        cnt        <= '0;
                        rd_valid   <= 1'b0;
                        state      <= (PRE_COUNT == '0) ? S_WAIT : S_PRE;
                    end else if ((state == S_DONE) && RD_START) begin
                        // After capture wr_ptr points at the oldest sample.
                        rd_ptr   <= wr_ptr;
                        beat_cnt <= '0;
                        rd_valid <= 1'b0;
                        state    <= S_READ;
                    end
                end

                S_PRE: begin
                    // Fill the pre-trigger window; triggers are ignored here.
                    if (SAMPLE_EN) begin
                        wr_ptr <= wr_ptr_inc;
                        cnt    <= cnt_inc;
                        if (cnt_inc == pre_count) begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (SAMPLE_EN) begin
                        wr_ptr <= wr_ptr_inc;
                        if (hit) begin
                            trig_addr <= wr_ptr;
                            cnt       <= post_cnt;
                            state     <= (post_cnt == '0) ? S_DONE : S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (SAMPLE_EN) begin
                        wr_ptr <= wr_ptr_inc;
                        cnt    <= cnt - 1'b1;
                        if (cnt == AW'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end

                S_READ: begin
                    if (!rd_valid) begin
                        // First read address was issued this cycle.
                        rd_valid <= 1'b1;
                    end else if (RD_READY) begin
                        rd_ptr   <= rd_ptr_inc;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == AW'(DEPTH - 1)) begin
                            rd_valid <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign RD_VALID  = rd_valid;
    assign RD_DATA   = rd_valid ? ram_dout : '0;
    assign RD_LAST   = rd_valid && (beat_cnt == AW'(DEPTH - 1));
    assign BUSY      = capturing || (state == S_READ);
    assign DONE      = (state == S_DONE) || (state == S_READ);
    assign TRIG_ADDR = trig_addr;

endmodule

// File: tb/tb_capture_sequencer.sv
// ----------------------------------------------------------------------------
// tb_capture_sequencer
//   Directed bench for capture_sequencer. Stimulus tasks drive the capture
//   scenarios; expected readout beats ({last, data}) are queued when a
//   readout is launched and a negedge monitor pops and compares every beat.
// ----------------------------------------------------------------------------
module tb_capture_sequencer;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b1;
    logic       ARM        = 1'b0;
    logic       ABORT      = 1'b0;
    logic       SAMPLE_EN  = 1'b0;
    logic [7:0] SAMPLE_IN  = 8'h00;
    logic [7:0] TRIG_MASK  = 8'h00;
    logic [7:0] TRIG_VALUE = 8'h00;
    logic [6:0] PRE_COUNT  = 7'd0;
    logic       RD_START   = 1'b0;
    logic       RD_READY   = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       RD_LAST;
    logic       BUSY;
    logic       DONE;
    logic [6:0] TRIG_ADDR;

    int checks     = 0;
    int failures   = 0;
    int beats_seen = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    capture_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .ARM        (ARM),
        .ABORT      (ABORT),
        .SAMPLE_EN  (SAMPLE_EN),
        .SAMPLE_IN  (SAMPLE_IN),
        .TRIG_MASK  (TRIG_MASK),
        .TRIG_VALUE (TRIG_VALUE),
        .PRE_COUNT  (PRE_COUNT),
        .RD_START   (RD_START),
        .RD_READY   (RD_READY),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .RD_LAST    (RD_LAST),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .TRIG_ADDR  (TRIG_ADDR)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        SAMPLE_IN = v;
        SAMPLE_EN = 1'b1;
        tick();
        SAMPLE_EN = 1'b0;
    endtask

    task automatic arm(input logic [7:0] mask, input logic [7:0] value, input logic [6:0] pre);
        TRIG_MASK  = mask;
        TRIG_VALUE = value;
        PRE_COUNT  = pre;
        ARM        = 1'b1;
        tick();
        ARM = 1'b0;
        chk("arm_busy", BUSY, 1);
        chk("arm_done_low", DONE, 0);
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return (cyc % 4 == 0) || (cyc % 4 == 3);  // 1,0,0,1 repeating
    endfunction

    // Launch a readout and clock until stop_at beats have transferred.
    task automatic readout(input int mode, input int stop_at);
        int cyc;
        beats_seen = 0;
        RD_READY   = ready_pat(mode, 0);
        RD_START   = 1'b1;
        tick();
        RD_START = 1'b0;
        chk("rd_addr_issue_cycle_invalid", RD_VALID, 0);
        tick();
        chk("rd_valid_latency", RD_VALID, 1);
        cyc = 1;
        while (beats_seen < stop_at && cyc < 2000) begin
            RD_READY = ready_pat(mode, cyc);
            tick();
            cyc++;
        end
        chk("rd_beat_count", beats_seen, stop_at);
    endtask

    task automatic check_readout_end();
        RD_READY = 1'b0;
        chk("end_rd_valid", RD_VALID, 0);
        chk("end_done", DONE, 0);
        chk("end_busy", BUSY, 0);
        chk("end_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (stall_prev && !RST) begin
            checks++;
            if (!RD_VALID || RD_DATA !== stall_data) begin
                failures++;
                $display("FAIL rd_stall_hold actual=%0b/%0h required=1/%0h",
                         RD_VALID, RD_DATA, stall_data);
            end
        end
        if (RD_VALID && RD_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected_beat actual=%0h required=none", {RD_LAST, RD_DATA});
            end else begin
                mon_e = exp_q.pop_front();
                if ({RD_LAST, RD_DATA} !== mon_e) begin
                    failures++;
                    $display("FAIL rd_beat_%0d actual=last%0b/%0h required=last%0b/%0h",
                             beats_seen, RD_LAST, RD_DATA, mon_e[8], mon_e[7:0]);
                end
            end
            beats_seen++;
        end
        stall_prev = RD_VALID && !RD_READY && !RST;
        stall_data = RD_DATA;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        int s;

        // Reset
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_rd_data", RD_DATA, 0);
        chk("rst_rd_last", RD_LAST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_trig_addr", TRIG_ADDR, 0);
        RST = 1'b0;
        tick();

        // Test 1: pre=16, exact match 0xA5 injected as sample 40, strobe gaps.
        arm(8'hFF, 8'hA5, 7'd16);
        for (int k = 0; k < 152; k++) begin
            v = (k == 40) ? 8'hA5 : 8'(k);
            send(v);
            if (k == 40) chk("t1_trig_addr", TRIG_ADDR, 40);
            if (k == 150) chk("t1_not_done_yet", DONE, 0);
            if (k % 7 == 6) tick();
        end
        chk("t1_done", DONE, 1);
        chk("t1_busy_low", BUSY, 0);
        for (int i = 0; i < 128; i++) begin
            s = 24 + i;
            v = (s == 40) ? 8'hA5 : 8'(s);
            exp_q.push_back({(i == 127), v});
        end
        readout(0, 128);
        check_readout_end();

        // Test 2: mask 0, pre 0: first strobe triggers, done after 128 strobes.
        arm(8'h00, 8'h00, 7'd0);
        for (int k = 0; k < 128; k++) begin
            send(8'(8'h80 + k));
            if (k == 0) chk("t2_trig_addr", TRIG_ADDR, 0);
            if (k == 126) chk("t2_not_done_127", DONE, 0);
        end
        chk("t2_done_128", DONE, 1);
        for (int i = 0; i < 128; i++) exp_q.push_back({(i == 127), 8'(8'h80 + i)});
        readout(0, 128);
        check_readout_end();

        // Test 3 + 4: pre=127, trigger on sample 200, readout with 1,0,0,1 ready.
        // Sample 60 equals the pattern but falls inside the pre-trigger window.
        arm(8'hFF, 8'h3C, 7'd127);
        for (int k = 0; k < 201; k++) begin
            v = (k == 200) ? 8'h3C : 8'(k);
            send(v);
            if (k == 199) chk("t3_not_done_199", DONE, 0);
        end
        chk("t3_done_on_trigger", DONE, 1);
        chk("t3_trig_addr", TRIG_ADDR, 72);
        for (int i = 0; i < 128; i++) begin
            s = 73 + i;
            v = (s == 200) ? 8'h3C : 8'(s);
            exp_q.push_back({(i == 127), v});
        end
        readout(1, 128);
        check_readout_end();

        // Test 5: ABORT together with a matching sample in WAIT_TRIG.
        arm(8'hFF, 8'h77, 7'd0);
        send(8'h10);
        send(8'h11);
        send(8'h12);
        ABORT     = 1'b1;
        SAMPLE_IN = 8'h77;
        SAMPLE_EN = 1'b1;
        tick();
        ABORT     = 1'b0;
        SAMPLE_EN = 1'b0;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_rd_valid", RD_VALID, 0);
        chk("abort_trig_addr_kept", TRIG_ADDR, 72);
        // ABORT and ARM together stay idle.
        ABORT = 1'b1;
        ARM   = 1'b1;
        tick();
        ABORT = 1'b0;
        ARM   = 1'b0;
        chk("abort_arm_busy", BUSY, 0);
        send(8'h77);
        chk("idle_no_trigger", TRIG_ADDR, 72);

        // Normal capture after abort: masked low-nibble trigger, pre=4.
        arm(8'h0F, 8'h05, 7'd4);
        for (int k = 0; k < 129; k++) begin
            send(8'(8'h40 + k));
            if (k == 5) chk("t5_trig_addr", TRIG_ADDR, 5);
            if (k == 127) chk("t5_not_done", DONE, 0);
        end
        chk("t5_done", DONE, 1);
        for (int i = 0; i < 128; i++) exp_q.push_back({(i == 127), 8'(8'h41 + i)});

        // Test 6: reset pulse after beat 50 of the readout.
        readout(0, 50);
        RD_READY = 1'b0;
        RST      = 1'b1;
        tick();
        chk("midrd_rst_rd_valid", RD_VALID, 0);
        chk("midrd_rst_rd_data", RD_DATA, 0);
        chk("midrd_rst_rd_last", RD_LAST, 0);
        chk("midrd_rst_busy", BUSY, 0);
        chk("midrd_rst_done", DONE, 0);
        chk("midrd_rst_trig_addr", TRIG_ADDR, 0);
        RST = 1'b0;
        exp_q.delete();
        beats_seen = 0;
        RD_READY   = 1'b1;
        // RD_START is ignored outside DONE.
        RD_START = 1'b1;
        tick();
        RD_START = 1'b0;
        repeat (20) tick();
        chk("post_rst_busy", BUSY, 0);
        chk("post_rst_rd_valid", RD_VALID, 0);
        chk("post_rst_no_beats", beats_seen, 0);
        RD_READY = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
